// File: rtl/seg_perimeter_rotator.sv
// Snake animation around the outer perimeter of N_DIGITS active-low 7-segment digits,
// with its own step prescaler, run/hold/idle sequencing, direction and tail length.
//
// state  | meaning
// IDLE   | display blank, head parked at 0, prescaler cleared
// RUN    | prescaler counting, head advances every DIV cycles
// HOLD   | prescaler and image frozen, step pulses advance one cell
module seg_perimeter_rotator #(
    parameter int N_DIGITS = 4,
    parameter int DIV      = 12500000,
    parameter int TAIL_LEN = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start_i,
    input  logic                                stop_i,
    input  logic                                en_i,
    input  logic                                dir_i,
    input  logic                                step_i,
    output logic [7*N_DIGITS-1:0]               seg_n_o,
    output logic [$clog2(2*N_DIGITS+4)-1:0]     pos_o,
    output logic                                wrap_o
);

    localparam int P  = 2*N_DIGITS + 4;
    localparam int PW = $clog2(P);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW = 7*N_DIGITS;
    localparam int LW = $clog2(SW);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   pos_q, pos_d;
    logic            dir_q, dir_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   seg_q, seg_d;
    logic            wrap_q, wrap_d;
    logic            adv;
    logic [SW-1:0]   lit;

    // Flat bit index of a perimeter cell; digit k occupies [7k+6:7k] with a at the top.
    function automatic int cell_bit(input int c);
        int b;
        if (c < N_DIGITS)                b = 7*c + 6;
        else if (c == N_DIGITS)          b = 7*(N_DIGITS-1) + 5;
        else if (c == N_DIGITS+1)        b = 7*(N_DIGITS-1) + 4;
        else if (c <= 2*N_DIGITS+1)      b = 7*(2*N_DIGITS+1-c) + 3;
        else if (c == 2*N_DIGITS+2)      b = 2;
        else                             b = 1;
        return b;
    endfunction

    function automatic int tail_cell(input logic [PW-1:0] p, input logic d, input int k);
        int c;
        c = d ? int'(p) + k : int'(p) - k;
        if (c >= P)     c = c - P;
        else if (c < 0) c = c + P;
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        adv     = 1'b0;
        case (state_q)
            S_IDLE: begin
                pos_d = '0;
                cnt_d = '0;
                if (start_i) state_d = en_i ? S_RUN : S_HOLD;
            end
            S_RUN: begin
                if (!en_i) begin
                    state_d = S_HOLD;
                end else if (cnt_q == CW'(DIV-1)) begin
                    cnt_d = '0;
                    adv   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (step_i) adv = 1'b1;
                if (en_i)   state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase

        if (adv) begin
            dir_d = dir_i;
            if (dir_i) begin
                pos_d  = (pos_q == '0) ? PW'(P-1) : pos_q - 1'b1;
                wrap_d = (pos_q == '0);
            end else begin
                pos_d  = (pos_q == PW'(P-1)) ? '0 : pos_q + 1'b1;
                wrap_d = (pos_q == PW'(P-1));
            end
        end

        // stop overrides every other request in the same cycle
        if (stop_i) begin
            state_d = S_IDLE;
            pos_d   = '0;
            cnt_d   = '0;
            dir_d   = dir_q;
            wrap_d  = 1'b0;
        end
    end

    // Image is built from next-state values so it lands together with pos and wrap.
    always_comb begin
        lit = '0;
        for (int k = 0; k < TAIL_LEN; k++) begin
            lit[LW'(cell_bit(tail_cell(pos_d, dir_d, k)))] = 1'b1;
        end
        seg_d = (state_d == S_IDLE) ? '1 : ~lit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pos_q   <= '0;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            seg_q   <= '1;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            wrap_q  <= wrap_d;
        end
    end

    assign seg_n_o = seg_q;
    assign pos_o   = pos_q;
    assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_seg_perimeter_rotator.sv
// Directed bench for seg_perimeter_rotator: expectations are queued as stimulus is
// driven and checked one sample point after the following clock edge.
module tb_seg_perimeter_rotator;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0, stop = 1'b0, en = 1'b0, dir = 1'b0, step = 1'b0;

    logic [27:0] seg_a, seg_b;
    logic [41:0] seg_c;
    logic [3:0]  pos_a, pos_b, pos_c;
    logic        wrap_a, wrap_b, wrap_c;

    always #5 clk = ~clk;

    seg_perimeter_rotator #(.N_DIGITS(4), .DIV(3), .TAIL_LEN(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start_i(start), .stop_i(stop), .en_i(en),
        .dir_i(dir), .step_i(step), .seg_n_o(seg_a), .pos_o(pos_a), .wrap_o(wrap_a));

    seg_perimeter_rotator #(.N_DIGITS(4), .DIV(3), .TAIL_LEN(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(start), .stop_i(stop), .en_i(en),
        .dir_i(dir), .step_i(step), .seg_n_o(seg_b), .pos_o(pos_b), .wrap_o(wrap_b));

    seg_perimeter_rotator #(.N_DIGITS(6), .DIV(1), .TAIL_LEN(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .start_i(start), .stop_i(stop), .en_i(en),
        .dir_i(dir), .step_i(step), .seg_n_o(seg_c), .pos_o(pos_c), .wrap_o(wrap_c));

    typedef struct {
        string       tag;
        int          which;
        logic [3:0]  pos;
        logic        wrap;
        logic        chk_seg;
        logic [41:0] seg;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   cur   = 0;

    localparam logic [6:0] BL = 7'h7f;

    function automatic logic [41:0] d4(input logic [6:0] d3, input logic [6:0] d2,
                                       input logic [6:0] d1, input logic [6:0] d0);
        return {14'b0, d3, d2, d1, d0};
    endfunction

    task automatic push(input string tag, input int which, input logic [3:0] p,
                        input logic w, input logic cs, input logic [41:0] s);
        exp_t e;
        e.tag = tag; e.which = which; e.pos = p; e.wrap = w; e.chk_seg = cs; e.seg = s;
        sb.push_back(e);
    endtask

    task automatic check_now();
        exp_t        e;
        logic [41:0] os;
        logic [3:0]  op;
        logic        ow;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.which)
                0:       begin os = {14'b0, seg_a}; op = pos_a; ow = wrap_a; end
                1:       begin os = {14'b0, seg_b}; op = pos_b; ow = wrap_b; end
                default: begin os = seg_c;          op = pos_c; ow = wrap_c; end
            endcase
            n_cmp++;
            assert (op === e.pos) else begin
                n_mis++;
                $error("FAIL %s pos got %0d want %0d", e.tag, op, e.pos);
            end
            n_cmp++;
            assert (ow === e.wrap) else begin
                n_mis++;
                $error("FAIL %s wrap got %b want %b", e.tag, ow, e.wrap);
            end
            if (e.chk_seg) begin
                n_cmp++;
                assert (os === e.seg) else begin
                    n_mis++;
                    $error("FAIL %s seg_n got %h want %h", e.tag, os, e.seg);
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        check_now();
    endtask

    // Two non-advancing prescaler cycles on dut_a; dir is wiggled on the first one.
    task automatic wait2(input logic d);
        dir = ~d;
        push("pre_adv", 0, 4'(cur), 1'b0, 1'b0, '0);
        cyc();
        dir = d;
        push("pre_adv", 0, 4'(cur), 1'b0, 1'b0, '0);
        cyc();
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        push("rst_a", 0, 4'd0, 1'b0, 1'b1, d4(BL, BL, BL, BL));
        push("rst_c", 2, 4'd0, 1'b0, 1'b1, {6{BL}});
        check_now();
        @(posedge clk); #1;
        rst_n = 1'b1;
        push("idle", 0, 4'd0, 1'b0, 1'b1, d4(BL, BL, BL, BL));
        cyc();

        // free-running clockwise lap
        start = 1'b1; en = 1'b1; dir = 1'b0;
        push("start_img", 0, 4'd0, 1'b0, 1'b1, d4(BL, BL, BL, 7'b0111111));
        cyc();
        start = 1'b0;
        cur = 0;
        for (int i = 1; i <= 12; i++) begin
            push("run_hold", 0, 4'(cur), 1'b0, 1'b0, '0); cyc();
            push("run_hold", 0, 4'(cur), 1'b0, 1'b0, '0); cyc();
            cur = i % 12;
            push("run_adv", 0, 4'(cur), (i == 12), 1'b0, '0);
            if (i == 1)  push("tail3_lap", 1, 4'd1, 1'b0, 1'b1, d4(BL, BL, 7'b0111111, 7'b0111101));
            if (i == 4)  push("pos4_img", 0, 4'd4, 1'b0, 1'b1, d4(7'b1011111, BL, BL, BL));
            if (i == 12) push("wrap_img", 0, 4'd0, 1'b1, 1'b1, d4(BL, BL, BL, 7'b0111111));
            cyc();
        end

        // direction changes and tail side flip
        wait2(1'b0); cur = 1;
        push("cw1", 0, 4'd1, 1'b0, 1'b0, '0);
        push("tail3_cw1", 1, 4'd1, 1'b0, 1'b1, d4(BL, BL, 7'b0111111, 7'b0111101));
        cyc();
        wait2(1'b1); cur = 0;
        push("ccw0", 0, 4'd0, 1'b0, 1'b1, d4(BL, BL, BL, 7'b0111111));
        push("tail3_flip", 1, 4'd0, 1'b0, 1'b1, d4(BL, 7'b0111111, 7'b0111111, 7'b0111111));
        cyc();
        wait2(1'b1); cur = 11;
        push("ccw_wrap", 0, 4'd11, 1'b1, 1'b1, d4(BL, BL, BL, 7'b1111101));
        push("tail3_ccw11", 1, 4'd11, 1'b1, 1'b1, d4(BL, BL, 7'b0111111, 7'b0111101));
        cyc();
        wait2(1'b1); cur = 10;
        push("ccw10", 0, 4'd10, 1'b0, 1'b1, d4(BL, BL, BL, 7'b1111011));
        cyc();

        // hold at terminal count, single steps, resume with preserved prescaler
        dir = 1'b0;
        push("cnt1", 0, 4'd10, 1'b0, 1'b0, '0); cyc();
        push("cnt2", 0, 4'd10, 1'b0, 1'b0, '0); cyc();
        en = 1'b0;
        push("hold_frz", 0, 4'd10, 1'b0, 1'b1, d4(BL, BL, BL, 7'b1111011)); cyc();
        push("hold_stay", 0, 4'd10, 1'b0, 1'b0, '0); cyc();
        step = 1'b1;
        push("step1", 0, 4'd11, 1'b0, 1'b1, d4(BL, BL, BL, 7'b1111101)); cyc();
        step = 1'b0;
        push("step1_stay", 0, 4'd11, 1'b0, 1'b0, '0); cyc();
        step = 1'b1;
        push("step2_wrap", 0, 4'd0, 1'b1, 1'b1, d4(BL, BL, BL, 7'b0111111)); cyc();
        step = 1'b0;
        push("step2_stay", 0, 4'd0, 1'b0, 1'b0, '0); cyc();
        en = 1'b1;
        push("resume", 0, 4'd0, 1'b0, 1'b0, '0); cyc();
        push("resume_adv", 0, 4'd1, 1'b0, 1'b0, '0); cyc();

        // start+stop together, restart, async reset mid-run
        start = 1'b1; stop = 1'b1;
        push("start_stop", 0, 4'd0, 1'b0, 1'b1, d4(BL, BL, BL, BL)); cyc();
        start = 1'b0; stop = 1'b0;
        push("idle_stay", 0, 4'd0, 1'b0, 1'b1, d4(BL, BL, BL, BL)); cyc();
        start = 1'b1;
        push("restart", 0, 4'd0, 1'b0, 1'b1, d4(BL, BL, BL, 7'b0111111)); cyc();
        start = 1'b0;
        push("re_cnt1", 0, 4'd0, 1'b0, 1'b0, '0); cyc();
        push("re_cnt2", 0, 4'd0, 1'b0, 1'b0, '0); cyc();
        push("re_adv", 0, 4'd1, 1'b0, 1'b1, d4(BL, BL, 7'b0111111, BL)); cyc();
        #2 rst_n = 1'b0;
        #1;
        push("async_rst", 0, 4'd0, 1'b0, 1'b1, d4(BL, BL, BL, BL));
        check_now();
        @(posedge clk); #1;
        push("rst_held", 0, 4'd0, 1'b0, 1'b1, d4(BL, BL, BL, BL));
        check_now();
        rst_n = 1'b1;

        // start into HOLD, step, then stop beats a simultaneous step
        en = 1'b0; start = 1'b1;
        push("start_hold", 0, 4'd0, 1'b0, 1'b1, d4(BL, BL, BL, 7'b0111111)); cyc();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push("hold_idle", 0, 4'd0, 1'b0, 1'b0, '0); cyc();
        end
        step = 1'b1;
        push("hold_step", 0, 4'd1, 1'b0, 1'b0, '0); cyc();
        stop = 1'b1;
        push("stop_step", 0, 4'd0, 1'b0, 1'b1, d4(BL, BL, BL, BL)); cyc();
        stop = 1'b0; step = 1'b0;

        // six digits, one step per cycle
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        en = 1'b1; dir = 1'b0; start = 1'b1;
        push("c_start", 2, 4'd0, 1'b0, 1'b1, {{5{BL}}, 7'b0111111}); cyc();
        start = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            push("c_run", 2, 4'(i % 16), (i == 16), 1'b0, '0);
            if (i == 7)  push("c_pos7", 2, 4'd7, 1'b0, 1'b1, {7'b1101111, {5{BL}}});
            if (i == 13) push("c_pos13", 2, 4'd13, 1'b0, 1'b1, {{5{BL}}, 7'b1110111});
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
